// File: rtl/icache_direct.sv
// Direct-mapped instruction cache in front of the fetch stage.
// A hit returns the word combinationally. A miss stalls fetch, sends one
// registered line request, then fills the line from a burst of in-order beats.
module icache_direct #(
    parameter int          NUM_LINES      = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        imem_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_LSB = OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [WORD_W-1:0]       cnt_q, cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;

    // Data and tag arrays carry no reset; the valid bits gate them.
    logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][31:0] data_q;
    logic [NUM_LINES-1:0][TAG_W-1:0]                tag_q;

    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              beat;
    logic              last_beat;
    logic              unused_addr_bits;

    assign word     = addr[OFF_W-1:2];
    assign idx      = addr[TAG_LSB-1:OFF_W];
    assign tag      = addr[31:TAG_LSB];
    // The latched request address doubles as the miss address for the fill.
    assign fill_idx = mem_addr_q[TAG_LSB-1:OFF_W];
    assign fill_tag = mem_addr_q[31:TAG_LSB];
    assign unused_addr_bits = ^addr[1:0];

    assign hit        = (state_q == S_IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign instr      = hit ? data_q[idx][word] : NOP_INSTR;
    assign imem_stall = ~hit;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    assign beat      = (state_q == S_FILL) && mem_rvalid;
    assign last_beat = beat && (cnt_q == WORD_W'(WORDS_PER_LINE - 1));

    // Next-state logic: miss detection, request handshake, beat counting, flush.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr[31:OFF_W], {OFF_W{1'b0}}};
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d   = S_FILL;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d      = S_IDLE;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flush mid-fill lets the burst finish but keeps its line invalid.
        if (flush) begin
            valid_d = '0;
            if (state_q != S_IDLE && !last_beat) flush_pend_d = 1'b1;
        end else if (last_beat && !flush_pend_q) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Line fill: each beat writes one word; the tag lands with the last beat.
    always_ff @(posedge clk) begin
        if (beat) data_q[fill_idx][cnt_q] <= mem_rdata;
        if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus a randomized access stream,
// checked against a line-table model of a 16x4 direct-mapped cache.
module tb_icache_direct;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] instr;
    logic        imem_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Model: one entry per line index, filled per the cache rules.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];

    icache_direct #(.NUM_LINES(16), .WORDS_PER_LINE(4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .addr(addr), .flush(flush), .instr(instr),
        .imem_stall(imem_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Compare the current lookup against the model (DUT assumed idle).
    task automatic look(input string tag, output bit hit);
        int li, wi;
        #1;
        li  = int'((addr >> 4) % 16);
        wi  = int'((addr >> 2) % 4);
        hit = m_valid[li] && (m_tag[li] == addr[31:8]);
        chk({tag, "_stall"}, {31'd0, imem_stall}, {31'd0, !hit});
        chk({tag, "_instr"}, instr, hit ? m_data[li][wi] : NOP);
        chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    endtask

    task automatic present(input logic [31:0] a, input bit fl, input string tag, output bit hit);
        @(negedge clk);
        addr = a; flush = fl; mem_ready = 1'b0; mem_rvalid = 1'b0;
        look(tag, hit);
        if (fl) clear_model();
    endtask

    // Act as instruction memory for one miss; entered in the miss cycle.
    task automatic serve(input logic [31:0] a, input int rdy_dly, input int gap,
                         input int flush_beat, input bit stray, input logic [31:0] base);
        logic [31:0] line;
        logic [31:0] bd [4];
        bit          killed;
        int          li;
        line   = a & ~32'hF;
        li     = int'((a >> 4) % 16);
        killed = 1'b0;
        for (int w = 0; w < 4; w++) bd[w] = (base != 0) ? base * (w + 1) : $urandom;
        for (int c = 0; c <= rdy_dly; c++) begin
            @(negedge clk);
            flush = 1'b0; mem_ready = (c == rdy_dly); mem_rvalid = stray; mem_rdata = $urandom;
            #1;
            chk("req_hi",    {31'd0, mem_req}, 32'd1);
            chk("req_addr",  mem_addr, line);
            chk("req_stall", {31'd0, imem_stall}, 32'd1);
            chk("req_instr", instr, NOP);
        end
        for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
                #1;
                chk("gap_req",   {31'd0, mem_req}, 32'd0);
                chk("gap_stall", {31'd0, imem_stall}, 32'd1);
            end
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = bd[w];
            flush = (w == flush_beat);
            if (flush) killed = 1'b1;
            #1;
            chk("beat_stall", {31'd0, imem_stall}, 32'd1);
            chk("beat_instr", instr, NOP);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; flush = 1'b0;
        if (killed) clear_model();
        else begin
            m_valid[li] = 1'b1;
            m_tag[li]   = a[31:8];
            for (int w = 0; w < 4; w++) m_data[li][w] = bd[w];
        end
    endtask

    initial begin
        bit hit;
        logic [31:0] ra;
        int guard;
        rst = 1'b0; addr = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_stall", {31'd0, imem_stall}, 32'd1);
        chk("rst_instr", instr, NOP);

        // Cold miss at 0x0, immediate ready, back-to-back beats 0x11..0x44.
        @(negedge clk);
        rst = 1'b1; addr = 32'h0;
        look("t1_miss", hit);
        serve(32'h0, 0, 0, -1, 1'b0, 32'h11);
        look("t1_hit", hit);
        chk("t1_word0", instr, 32'h11);

        // Same-line hit on word 2.
        present(32'h8, 1'b0, "t2_hit", hit);
        chk("t2_word2", instr, 32'h33);

        // Conflict miss with ready held low for three cycles, then re-miss at 0x0.
        present(32'h104, 1'b0, "t3_miss", hit);
        serve(32'h104, 3, 0, -1, 1'b0, 32'h0);
        look("t3_hit", hit);
        present(32'h0, 1'b0, "t3_evict", hit);
        chk("t3_evicted", {31'd0, imem_stall}, 32'd1);
        serve(32'h0, 0, 0, -1, 1'b0, 32'h0);
        look("t3_refill", hit);

        // Two-cycle gaps between beats.
        present(32'h24, 1'b0, "t4_miss", hit);
        serve(32'h24, 1, 2, -1, 1'b0, 32'h0);
        look("t4_hit", hit);

        // Flush during fill: line stays invalid and is requested again.
        present(32'h34, 1'b0, "t5_miss", hit);
        serve(32'h34, 0, 0, 1, 1'b0, 32'h0);
        look("t5_killed", hit);
        chk("t5_still_stall", {31'd0, imem_stall}, 32'd1);
        serve(32'h34, 0, 0, -1, 1'b0, 32'h0);
        look("t5_hit", hit);

        // Flush in idle: hit this cycle, miss the next.
        present(32'h34, 1'b1, "t6_flush_hit", hit);
        present(32'h34, 1'b0, "t6_miss", hit);
        chk("t6_missed", {31'd0, imem_stall}, 32'd1);
        serve(32'h34, 0, 0, -1, 1'b0, 32'h0);
        look("t6_hit", hit);

        // Reset mid-fill with stray beats afterwards.
        present(32'h50, 1'b0, "t7_miss", hit);
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001;
        @(negedge clk); mem_rdata = 32'hDEAD_0002;
        @(negedge clk); rst = 1'b0; mem_rvalid = 1'b0;
        #1;
        clear_model();
        chk("t7_rst_req",   {31'd0, mem_req}, 32'd0);
        chk("t7_rst_addr",  mem_addr, 32'd0);
        chk("t7_rst_stall", {31'd0, imem_stall}, 32'd1);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0003;
        @(negedge clk); rst = 1'b1; mem_rdata = 32'hDEAD_0004;
        look("t7_after_rst", hit);
        serve(32'h50, 1, 0, -1, 1'b1, 32'h0);
        look("t7_hit", hit);

        // Randomized stream over a few tags so hits, conflicts and flushes mix.
        for (int it = 0; it < 150; it++) begin
            ra = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4)
               | ($urandom_range(0, 3) << 2);
            present(ra, ($urandom_range(0, 9) == 0), "rnd", hit);
            guard = 0;
            while (!hit && guard < 3) begin
                serve(ra, $urandom_range(0, 2), $urandom_range(0, 1),
                      (guard == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
                      $urandom_range(0, 1) == 1, 32'h0);
                look("rnd_fill", hit);
                guard++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
